reg_file_sb: RTL and testbench

//   Parametrised multi-entry register file that generalises the single 32-bit register.
//   It provides 2 combinational read ports, 1 write port with byte enables, optional

---
 rtl/reg_file_sb.sv | 89 ++++++++
 tb/tb_reg_file_sb.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Multi-entry register file with two combinational read ports, one byte-enabled write port,
// optional write-to-read bypass, optional hardwired-zero entry 0 and a per-entry busy scoreboard.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    reg_write,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    issue_valid,
    input  logic [ADDR_WIDTH-1:0]   issue_addr,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_a,
    output logic [DATA_WIDTH-1:0]   rd_data_a,
    output logic                    busy_a,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_b,
    output logic [DATA_WIDTH-1:0]   rd_data_b,
    output logic                    busy_b,
    output logic [ADDR_WIDTH:0]     busy_count
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_next;
    logic [ADDR_WIDTH:0]   busy_count_next;
    logic [DATA_WIDTH-1:0] merged;
    logic                  wr_en;
    logic                  issue_en;

    // Entry 0 swallows writes and issues when it is hardwired to zero.
    assign wr_en    = reg_write && !((ZERO_REG != 0) && (wr_addr == '0));
    assign issue_en = issue_valid && !((ZERO_REG != 0) && (issue_addr == '0));

    always_comb begin
        merged = mem[wr_addr];
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
        end
    end

    always_comb begin
        rd_data_a = mem[rd_addr_a];
        if ((BYPASS != 0) && reg_write && (wr_addr == rd_addr_a)) rd_data_a = merged;
        if ((ZERO_REG != 0) && (rd_addr_a == '0)) rd_data_a = '0;
    end

    always_comb begin
        rd_data_b = mem[rd_addr_b];
        if ((BYPASS != 0) && reg_write && (wr_addr == rd_addr_b)) rd_data_b = merged;
        if ((ZERO_REG != 0) && (rd_addr_b == '0)) rd_data_b = '0;
    end

    assign busy_a = busy[rd_addr_a];
    assign busy_b = busy[rd_addr_b];

    // Clear first, then set: a new producer issued in the same cycle keeps the entry busy.
    always_comb begin
        busy_next = busy;
        if (reg_write) busy_next[wr_addr] = 1'b0;
        if (issue_en) busy_next[issue_addr] = 1'b1;
    end

    always_comb begin
        busy_count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_count_next = busy_count_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_en) mem[wr_addr] <= merged;
            busy       <= busy_next;
            busy_count <= busy_count_next;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file and scoreboard.
module tb_reg_file_sb;

    logic        clk;
    logic        reset_n;
    logic        reg_write;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic        busy_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        busy_b;
    logic [5:0]  busy_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_mem[32];
    bit          m_busy[32];

    reg_file_sb dut (
        .clk(clk), .reset_n(reset_n),
        .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .busy_a(busy_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .busy_b(busy_b),
        .busy_count(busy_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] data,
                                            input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (data & mask) | (old & ~mask);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
        if (reg_write && wr_addr == addr) return m_merge(m_mem[addr], wr_data, wr_be);
        return m_mem[addr];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic m_clock();
        if (reg_write && wr_addr != 5'd0) m_mem[wr_addr] = m_merge(m_mem[wr_addr], wr_data, wr_be);
        if (reg_write) m_busy[wr_addr] = 1'b0;
        if (issue_valid && issue_addr != 5'd0) m_busy[issue_addr] = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        reg_write   = 1'b0;
        wr_addr     = 5'd0;
        wr_data     = 32'h0;
        wr_be       = 4'h0;
        issue_valid = 1'b0;
        issue_addr  = 5'd0;
    endtask

    task automatic drive_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        reg_write = 1'b1;
        wr_addr   = a;
        wr_data   = d;
        wr_be     = be;
    endtask

    task automatic drive_issue(input logic [4:0] a);
        issue_valid = 1'b1;
        issue_addr  = a;
    endtask

    // One clock: model advances with the inputs present at the edge, inputs change 1 after.
    task automatic cycle();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd31;
        reset_n   = 1'b0;
        m_reset();
        #1;
        checks++;
        if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd: a=%h b=%h expected 0", rd_data_a, rd_data_b);
        end
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || busy_count !== 6'd0) begin
            errors++;
            $display("FAIL reset_busy: a=%b b=%b cnt=%0d expected 0", busy_a, busy_b, busy_count);
        end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        drive_write(5'd5, 32'h12345678, 4'hF);
        cycle();
        set_idle();
        rd_addr_a = 5'd5;
        #1;
        checks++;
        if (rd_data_a !== 32'h12345678) begin
            errors++;
            $display("FAIL write_read: got %h expected 12345678", rd_data_a);
        end
        wr_addr = 5'd5;
        wr_data = 32'h87654321;
        wr_be   = 4'hF;
        cycle();
        set_idle();
        #1;
        checks++;
        if (rd_data_a !== 32'h12345678) begin
            errors++;
            $display("FAIL no_write_hold: got %h expected 12345678", rd_data_a);
        end
    endtask

    task automatic test_byte_enable();
        rd_addr_a = 5'd5;
        drive_write(5'd5, 32'hABCDEF01, 4'b0101);
        #1;
        checks++;
        if (rd_data_a !== 32'h12CD5601) begin
            errors++;
            $display("FAIL be_bypass: got %h expected 12cd5601", rd_data_a);
        end
        cycle();
        set_idle();
        #1;
        checks++;
        if (rd_data_a !== 32'h12CD5601) begin
            errors++;
            $display("FAIL be_stored: got %h expected 12cd5601", rd_data_a);
        end
    endtask

    task automatic test_zero_reg();
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd0;
        drive_write(5'd0, 32'hFFFFFFFF, 4'hF);
        drive_issue(5'd0);
        #1;
        checks++;
        if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
            errors++;
            $display("FAIL zero_bypass: a=%h b=%h expected 0", rd_data_a, rd_data_b);
        end
        cycle();
        set_idle();
        #1;
        checks++;
        if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
            errors++;
            $display("FAIL zero_stored: a=%h b=%h expected 0", rd_data_a, rd_data_b);
        end
        checks++;
        if (busy_a !== 1'b0 || busy_count !== 6'd0) begin
            errors++;
            $display("FAIL zero_issue: busy=%b cnt=%0d expected 0/0", busy_a, busy_count);
        end
    endtask

    task automatic test_scoreboard();
        rd_addr_a = 5'd3;
        drive_issue(5'd3);
        cycle();
        set_idle();
        #1;
        checks++;
        if (busy_a !== 1'b1 || busy_count !== 6'd1) begin
            errors++;
            $display("FAIL sb_issue: busy=%b cnt=%0d expected 1/1", busy_a, busy_count);
        end
        drive_issue(5'd3);
        drive_write(5'd3, 32'hCAFE0003, 4'hF);
        cycle();
        set_idle();
        #1;
        checks++;
        if (busy_a !== 1'b1 || busy_count !== 6'd1) begin
            errors++;
            $display("FAIL sb_set_wins: busy=%b cnt=%0d expected 1/1", busy_a, busy_count);
        end
        drive_write(5'd3, 32'h0BADF00D, 4'h0);
        cycle();
        set_idle();
        #1;
        checks++;
        if (busy_a !== 1'b0 || busy_count !== 6'd0) begin
            errors++;
            $display("FAIL sb_clear: busy=%b cnt=%0d expected 0/0", busy_a, busy_count);
        end
        checks++;
        if (rd_data_a !== 32'hCAFE0003) begin
            errors++;
            $display("FAIL sb_be0_data: got %h expected cafe0003", rd_data_a);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 7; i++) begin
            drive_write(5'(i), $urandom, 4'hF);
            if (i <= 3) drive_issue(5'(7 + i));
            cycle();
            set_idle();
        end
        rd_addr_a = 5'd1;
        rd_addr_b = 5'd8;
        #1;
        checks++;
        if (busy_count !== 6'd3 || busy_b !== 1'b1 || rd_data_a !== m_mem[1]) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d busy_b=%b a=%h expected 3/1/%h",
                     busy_count, busy_b, rd_data_a, m_mem[1]);
        end
        reset_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0 || busy_count !== 6'd0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: a=%h b=%h cnt=%0d busy_b=%b expected all 0",
                     rd_data_a, rd_data_b, busy_count, busy_b);
        end
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_r31();
        logic [31:0] vals [3];
        logic [31:0] exp;
        vals[0] = 32'h00000001;
        vals[1] = 32'hFFFFFFFF;
        vals[2] = 32'h00000000;
        rd_addr_b = 5'd31;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(vals[k]);
            drive_write(5'd31, vals[k], 4'hF);
            cycle();
            set_idle();
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (rd_data_b !== exp) begin
                errors++;
                $display("FAIL r31_case%0d: got %h expected %h", k, rd_data_b, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ea, eb;
        for (int n = 0; n < 300; n++) begin
            reg_write   = ($urandom_range(0, 99) < 60);
            wr_addr     = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            wr_data     = $urandom;
            wr_be       = 4'($urandom_range(0, 15));
            issue_valid = ($urandom_range(0, 99) < 50);
            issue_addr  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            rd_addr_a   = ($urandom_range(0, 1) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr_b   = ($urandom_range(0, 3) == 0) ? rd_addr_a : 5'($urandom_range(0, 3));
            #1;
            ea = m_read(rd_addr_a);
            eb = m_read(rd_addr_b);
            checks++;
            if (rd_data_a !== ea || rd_data_b !== eb) begin
                errors++;
                $display("FAIL rand_rd[%0d]: a=%h b=%h expected %h %h", n, rd_data_a, rd_data_b, ea, eb);
            end
            checks++;
            if (busy_a !== m_busy[rd_addr_a] || busy_b !== m_busy[rd_addr_b] ||
                busy_count !== 6'(m_count())) begin
                errors++;
                $display("FAIL rand_busy[%0d]: a=%b b=%b cnt=%0d expected %b %b %0d", n, busy_a,
                         busy_b, busy_count, m_busy[rd_addr_a], m_busy[rd_addr_b], m_count());
            end
            cycle();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_zero_reg();
        test_scoreboard();
        test_async_reset();
        test_r31();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
